// File: rtl/conv_pkg.sv
// conv_pkg
//   Shared types and constants for the convolution compute scheduler.
//   - sched_state_t : scheduler FSM state encoding (IDLE encodes as 0)
//   - sched_tag_t   : per-element tag {valid, first, last} carried alongside
//                     the multiplier pipeline to frame accumulator groups
//   - SCHED_PIPE_LAT_DEFAULT : issue-to-multiplier-output latency
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_WAIT_KRN = 3'd2,
    S_RUN      = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } sched_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } sched_tag_t;

  localparam int SCHED_PIPE_LAT_DEFAULT = 4;

endpackage

// File: rtl/sched_tag_pipe.sv
// sched_tag_pipe
//   DEPTH-stage shift register of sched_tag_t, cleared by async reset.
//   Ports:
//     clk, reset_n : clock, async active-low reset
//     i_tag        : tag entering stage 0
//     o_tag        : tag leaving the last stage (DEPTH cycles later)
module sched_tag_pipe
  import conv_pkg::*;
#(
  parameter int DEPTH = SCHED_PIPE_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  sched_tag_t i_tag,
  output sched_tag_t o_tag
);

  sched_tag_t r_stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/conv_compute_sched.sv
// conv_compute_sched
//   Compute-side scheduler: walks output map (o) -> tile (t) -> input map (d,
//   innermost), drives image/kernel read addresses, the multiplier `next`
//   strobe and accumulator group framing aligned to multiplier output.
//   Ports:
//     clk, reset_n              : clock, async active-low reset
//     start                     : one-cycle pulse, accepted in IDLE/DONE only
//     cfg_num_tiles/in/out_maps : T, D1, D2 (latched on accepted start)
//     krn_blk_valid[1:0]        : kernel block b is loaded for next map using b
//     krn_blk_release[1:0]      : one-cycle pulse, block b may be overwritten
//     out_almostfull            : downstream cannot take a new group
//     img_rd_addr, krn_rd_addr, krn_sel_blk : read addresses (registered)
//     mult_next                 : multiplier input valid, 1 cycle after issue
//     acc_start, acc_stop       : first/last of group at multiplier output
//     busy, done, cfg_err       : status levels
//     dbg_state                 : current FSM state
//   Optional build macro SCHED_PERF_CNT_EN adds perf_stall_cycles[31:0].
//
//   Flow control: a kernel block is consumed once krn_blk_valid[o[0]] is seen
//   in WAIT_KRN and handed back by a release pulse after its last read.
//   out_almostfull is a stop request sampled only before the first element of
//   a group; once a group starts, all D1 elements issue back-to-back.
module conv_compute_sched
  import conv_pkg::*;
#(
  parameter int IMG_ADDR_W = 13,
  parameter int KRN_ADDR_W = 9,
  parameter int CNT_W      = 32,
  parameter int PIPE_LAT   = SCHED_PIPE_LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      cfg_num_tiles,
  input  logic [CNT_W-1:0]      cfg_num_in_maps,
  input  logic [CNT_W-1:0]      cfg_num_out_maps,
  input  logic [1:0]            krn_blk_valid,
  output logic [1:0]            krn_blk_release,
  input  logic                  out_almostfull,
  output logic [IMG_ADDR_W-1:0] img_rd_addr,
  output logic [KRN_ADDR_W-1:0] krn_rd_addr,
  output logic                  krn_sel_blk,
  output logic                  mult_next,
  output logic                  acc_start,
  output logic                  acc_stop,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output sched_state_t          dbg_state
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam int                PROD_W    = IMG_ADDR_W + KRN_ADDR_W + 2;
  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0]  IMG_LIMIT = ONE << IMG_ADDR_W;
  localparam logic [CNT_W-1:0]  KRN_LIMIT = ONE << KRN_ADDR_W;

  sched_state_t     r_state;
  logic [CNT_W-1:0] r_t_cfg, r_d1_cfg, r_d2_cfg;
  logic [CNT_W-1:0] r_o, r_t, r_d;
  logic [CNT_W-1:0] r_base;      // d*T, advanced by T per d step
  logic [CNT_W-1:0] r_drain_cnt;
  logic             r_map_done;  // last element of map o has issued
  logic             r_issue;
  sched_tag_t       r_tag;
  sched_tag_t       w_tag_out;

  logic              w_cfg_zero, w_cfg_bad, w_t_big, w_d_big;
  logic [PROD_W-1:0] w_prod;
  logic              w_d_last, w_issue;

  // Range checks: once T <= 2^IMG_ADDR_W and D1 <= 2^KRN_ADDR_W hold, the
  // product fits in the narrow multiplier; otherwise the flags already trip.
  assign w_cfg_zero = (r_t_cfg == '0) || (r_d1_cfg == '0) || (r_d2_cfg == '0);
  assign w_t_big    = (r_t_cfg > IMG_LIMIT);
  assign w_d_big    = (r_d1_cfg > KRN_LIMIT);
  assign w_prod     = PROD_W'(r_t_cfg[IMG_ADDR_W:0]) * PROD_W'(r_d1_cfg[KRN_ADDR_W:0]);
  assign w_cfg_bad  = w_t_big || w_d_big || (w_prod > PROD_W'(IMG_LIMIT));

  assign w_d_last = (r_d == r_d1_cfg - ONE);
  assign w_issue  = (r_state == S_RUN) && !r_map_done &&
                    ((r_d != '0) || !out_almostfull);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_t_cfg         <= '0;
      r_d1_cfg        <= '0;
      r_d2_cfg        <= '0;
      r_o             <= '0;
      r_t             <= '0;
      r_d             <= '0;
      r_base          <= '0;
      r_drain_cnt     <= '0;
      r_map_done      <= 1'b0;
      r_issue         <= 1'b0;
      r_tag           <= '0;
      img_rd_addr     <= '0;
      krn_rd_addr     <= '0;
      krn_sel_blk     <= 1'b0;
      mult_next       <= 1'b0;
      krn_blk_release <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      mult_next       <= r_issue;
      r_issue         <= 1'b0;
      r_tag           <= '0;
      krn_blk_release <= '0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_t_cfg  <= cfg_num_tiles;
            r_d1_cfg <= cfg_num_in_maps;
            r_d2_cfg <= cfg_num_out_maps;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_cfg_zero || w_cfg_bad) begin
            cfg_err <= !w_cfg_zero;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_o        <= '0;
            r_t        <= '0;
            r_d        <= '0;
            r_base     <= '0;
            r_map_done <= 1'b0;
            r_state    <= S_WAIT_KRN;
          end
        end
        S_WAIT_KRN: begin
          if (krn_blk_valid[r_o[0]]) r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_map_done) begin
            // Cycle after the map's final issue: hand the block back.
            krn_blk_release <= {r_o[0], !r_o[0]};
            r_map_done      <= 1'b0;
            if (r_o == r_d2_cfg - ONE) begin
              r_drain_cnt <= '0;
              r_state     <= S_DRAIN;
            end else begin
              r_o     <= r_o + ONE;
              r_state <= S_WAIT_KRN;
            end
          end else if (w_issue) begin
            img_rd_addr <= IMG_ADDR_W'(r_base + r_t);
            krn_rd_addr <= r_d[KRN_ADDR_W-1:0];
            krn_sel_blk <= r_o[0];
            r_issue     <= 1'b1;
            r_tag       <= '{valid: 1'b1, first: (r_d == '0), last: w_d_last};
            if (!w_d_last) begin
              r_d    <= r_d + ONE;
              r_base <= r_base + r_t_cfg;
            end else begin
              r_d    <= '0;
              r_base <= '0;
              if (r_t == r_t_cfg - ONE) begin
                r_t        <= '0;
                r_map_done <= 1'b1;
              end else begin
                r_t <= r_t + ONE;
              end
            end
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == CNT_W'(PIPE_LAT - 1)) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // r_tag is aligned with the address outputs, so DEPTH=PIPE_LAT more stages
  // lands it on the multiplier output cycle.
  sched_tag_pipe #(.DEPTH(PIPE_LAT)) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_tag   (r_tag),
    .o_tag   (w_tag_out)
  );

  assign acc_start = w_tag_out.valid & w_tag_out.first;
  assign acc_stop  = w_tag_out.valid & w_tag_out.last;
  assign dbg_state = r_state;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_stall <= '0;
    end else if (((r_state == S_IDLE) || (r_state == S_DONE)) && start) begin
      r_perf_stall <= '0;
    end else if (((r_state == S_WAIT_KRN) || ((r_state == S_RUN) && !w_issue)) &&
                 (r_perf_stall != '1)) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_conv_compute_sched.sv
// tb_conv_compute_sched
//   Directed and randomized passes for conv_compute_sched. The reference
//   model lists every element of a pass from nested (o, t, d) loops and
//   derives the required timing relations between issue, tags, release and
//   done from the observed issue cycles.
module tb_conv_compute_sched;
  import conv_pkg::*;

  localparam int IMG_ADDR_W = 13;
  localparam int KRN_ADDR_W = 9;
  localparam int CNT_W      = 32;
  localparam int PIPE_LAT   = 4;

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  start = 1'b0;
  logic [CNT_W-1:0]      cfg_t = '0, cfg_d1 = '0, cfg_d2 = '0;
  logic [1:0]            krn_blk_valid = '0;
  logic                  out_almostfull = 1'b0;
  logic [1:0]            krn_blk_release;
  logic [IMG_ADDR_W-1:0] img_rd_addr;
  logic [KRN_ADDR_W-1:0] krn_rd_addr;
  logic                  krn_sel_blk, mult_next, acc_start, acc_stop;
  logic                  busy, done, cfg_err;
  sched_state_t          dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv_compute_sched #(
    .IMG_ADDR_W(IMG_ADDR_W), .KRN_ADDR_W(KRN_ADDR_W),
    .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_num_tiles(cfg_t), .cfg_num_in_maps(cfg_d1), .cfg_num_out_maps(cfg_d2),
    .krn_blk_valid(krn_blk_valid), .krn_blk_release(krn_blk_release),
    .out_almostfull(out_almostfull),
    .img_rd_addr(img_rd_addr), .krn_rd_addr(krn_rd_addr), .krn_sel_blk(krn_sel_blk),
    .mult_next(mult_next), .acc_start(acc_start), .acc_stop(acc_stop),
    .busy(busy), .done(done), .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  bit                    rec = 1'b0;
  logic [IMG_ADDR_W-1:0] prev_img;
  logic [KRN_ADDR_W-1:0] prev_krn;
  logic                  prev_sel;
  int                    obs_mn_cyc[$];
  logic [IMG_ADDR_W-1:0] obs_img[$];
  logic [KRN_ADDR_W-1:0] obs_krn[$];
  logic                  obs_sel[$];
  int                    obs_acc_cyc[$];
  logic                  obs_acc_s[$], obs_acc_e[$];
  int                    obs_rel_cyc[$];
  logic [1:0]            obs_rel_val[$];
  int                    done_cyc = -1;
  bit                    af_hist [0:16383];
  int                    start_cyc;

  // mult_next follows the issue cycle by one, so the issued addresses are
  // the values seen on the previous negedge.
  always @(negedge clk) begin
    if (rec) begin
      if (mult_next) begin
        obs_mn_cyc.push_back(cyc);
        obs_img.push_back(prev_img);
        obs_krn.push_back(prev_krn);
        obs_sel.push_back(prev_sel);
      end
      if (acc_start || acc_stop) begin
        obs_acc_cyc.push_back(cyc);
        obs_acc_s.push_back(acc_start);
        obs_acc_e.push_back(acc_stop);
      end
      if (krn_blk_release != 2'b00) begin
        obs_rel_cyc.push_back(cyc);
        obs_rel_val.push_back(krn_blk_release);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
    end
    prev_img = img_rd_addr;
    prev_krn = krn_rd_addr;
    prev_sel = krn_sel_blk;
  end

  // ---------------- driver ----------------
  int v_cyc, deassert_cyc;

  // af_mode: 0 = never full, 1 = random, 2 = full during first group for 8 cycles
  // krn_mode: 0 = both blocks valid, 1 = block 1 raised 9 cycles after release 0
  task automatic run_pass(input int t, input int d1, input int d2,
                          input int af_mode, input int krn_mode, input int bound);
    int af_on_cyc;
    int af_state;
    obs_mn_cyc.delete(); obs_img.delete(); obs_krn.delete(); obs_sel.delete();
    obs_acc_cyc.delete(); obs_acc_s.delete(); obs_acc_e.delete();
    obs_rel_cyc.delete(); obs_rel_val.delete();
    for (int i = 0; i < 16384; i++) af_hist[i] = 1'b0;
    done_cyc = -1; v_cyc = -1; deassert_cyc = -1; af_state = 0; af_on_cyc = 0;
    out_almostfull = 1'b0;
    krn_blk_valid = (krn_mode == 1) ? 2'b01 : 2'b11;
    cfg_t = CNT_W'(t); cfg_d1 = CNT_W'(d1); cfg_d2 = CNT_W'(d2);
    rec = 1'b1;
    start = 1'b1;
    start_cyc = cyc;
    for (int n = 0; n < bound && done_cyc < 0; n++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (af_mode == 1) begin
        out_almostfull = ($urandom_range(0, 2) == 0);
      end else if (af_mode == 2) begin
        if (af_state == 0 && obs_mn_cyc.size() == 1) begin
          out_almostfull = 1'b1; af_state = 1; af_on_cyc = cyc;
        end else if (af_state == 1 && cyc == af_on_cyc + 8) begin
          out_almostfull = 1'b0; af_state = 2; deassert_cyc = cyc;
        end
      end
      if (cyc - start_cyc < 16384) af_hist[cyc - start_cyc] = out_almostfull;
      if (krn_mode == 1 && v_cyc < 0 && obs_rel_cyc.size() > 0 &&
          cyc == obs_rel_cyc[0] + 9) begin
        krn_blk_valid = 2'b11;
        v_cyc = cyc;
      end
    end
    out_almostfull = 1'b0;
    rec = 1'b0;
    chk("pass_done_seen", (done_cyc >= 0), 1);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_pass(input int t, input int d1, input int d2);
    logic [IMG_ADDR_W-1:0] exp_img_q[$];
    logic [KRN_ADDR_W-1:0] exp_krn_q[$];
    logic                  exp_sel_q[$], exp_first_q[$], exp_last_q[$];
    int                    exp_acc_q[$];
    logic                  exp_s_q[$], exp_e_q[$];
    bit                    zero_cfg, bad_cfg;
    int                    total, n, last_k;
    zero_cfg = (t == 0) || (d1 == 0) || (d2 == 0);
    bad_cfg  = !zero_cfg && ((longint'(t) * longint'(d1) > 64'd8192) || (d1 > 512));
    if (zero_cfg || bad_cfg) begin
      chk("cfg_done_lat", done_cyc - start_cyc, 2);
      chk("cfg_err", cfg_err, bad_cfg);
      chk("cfg_no_issue", obs_mn_cyc.size(), 0);
      chk("cfg_busy", busy, 0);
      return;
    end
    for (int o = 0; o < d2; o++)
      for (int tt = 0; tt < t; tt++)
        for (int d = 0; d < d1; d++) begin
          exp_img_q.push_back(IMG_ADDR_W'(d * t + tt));
          exp_krn_q.push_back(KRN_ADDR_W'(d));
          exp_sel_q.push_back(o[0]);
          exp_first_q.push_back(d == 0);
          exp_last_q.push_back(d == d1 - 1);
        end
    total = exp_img_q.size();
    chk("n_issue", obs_mn_cyc.size(), total);
    n = (obs_mn_cyc.size() < total) ? obs_mn_cyc.size() : total;
    for (int k = 0; k < n; k++) begin
      chk("img_addr", obs_img[k], exp_img_q[k]);
      chk("krn_addr", obs_krn[k], exp_krn_q[k]);
      chk("krn_sel", obs_sel[k], exp_sel_q[k]);
      if (!exp_first_q[k]) chk("back_to_back", obs_mn_cyc[k] - obs_mn_cyc[k-1], 1);
      else chk("af_gate", af_hist[obs_mn_cyc[k] - 2 - start_cyc], 0);
      if (exp_first_q[k] || exp_last_q[k]) begin
        exp_acc_q.push_back(obs_mn_cyc[k] + PIPE_LAT - 1);
        exp_s_q.push_back(exp_first_q[k]);
        exp_e_q.push_back(exp_last_q[k]);
      end
    end
    chk("n_acc_events", obs_acc_cyc.size(), exp_acc_q.size());
    for (int k = 0; k < exp_acc_q.size() && k < obs_acc_cyc.size(); k++) begin
      chk("acc_cycle", obs_acc_cyc[k], exp_acc_q[k]);
      chk("acc_start", obs_acc_s[k], exp_s_q[k]);
      chk("acc_stop", obs_acc_e[k], exp_e_q[k]);
    end
    chk("n_release", obs_rel_cyc.size(), d2);
    if (n == total) begin
      for (int o = 0; o < d2 && o < obs_rel_cyc.size(); o++) begin
        last_k = (o + 1) * t * d1 - 1;
        chk("release_cycle", obs_rel_cyc[o], obs_mn_cyc[last_k]);
        chk("release_blk", obs_rel_val[o], (o % 2 == 0) ? 2'b01 : 2'b10);
      end
      chk("done_lat", done_cyc, obs_mn_cyc[total-1] + PIPE_LAT);
    end
    chk("done_level", done, 1);
    chk("busy_end", busy, 0);
    chk("cfg_err_clear", cfg_err, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_img"}, img_rd_addr, 0);
    chk({tag, "_krn"}, krn_rd_addr, 0);
    chk({tag, "_sel"}, krn_sel_blk, 0);
    chk({tag, "_mnext"}, mult_next, 0);
    chk({tag, "_accs"}, acc_start, 0);
    chk({tag, "_acce"}, acc_stop, 0);
    chk({tag, "_rel"}, krn_blk_release, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, cfg_err, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int rt, rd1, rd2;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    @(negedge clk); #1;

    // Basic walk: expect addresses 0,2,1,3 and block 0 released.
    run_pass(2, 2, 1, 0, 0, 200);
    check_pass(2, 2, 1);
    if (obs_mn_cyc.size() > 0) chk("first_issue_lat", obs_mn_cyc[0] - start_cyc, 5);

    // Kernel block 1 arrives late; reads resume WAIT->RUN->issue->next.
    run_pass(2, 2, 2, 0, 1, 300);
    check_pass(2, 2, 2);
    if (obs_mn_cyc.size() == 8 && v_cyc >= 0) chk("krn_wait_resume", obs_mn_cyc[4] - v_cyc, 3);
    else chk("krn_wait_seen", 0, 1);

    // Backpressure raised mid-group: group finishes, next waits for release.
    run_pass(2, 4, 1, 2, 0, 300);
    check_pass(2, 4, 1);
    if (obs_mn_cyc.size() == 8 && deassert_cyc >= 0) chk("af_resume", obs_mn_cyc[4] - deassert_cyc, 2);
    else chk("af_seen", 0, 1);

    // Configuration boundaries.
    run_pass(3, 0, 2, 0, 0, 50);    check_pass(3, 0, 2);
    run_pass(4096, 3, 1, 0, 0, 50); check_pass(4096, 3, 1);
    run_pass(1, 513, 1, 0, 0, 50);  check_pass(1, 513, 1);
    run_pass(8193, 1, 1, 0, 0, 50); check_pass(8193, 1, 1);
    run_pass(16, 512, 1, 0, 0, 9000); check_pass(16, 512, 1);

    // Single input map: start and stop coincide.
    run_pass(3, 1, 2, 0, 0, 200);
    check_pass(3, 1, 2);

    // Reset in the middle of a run, then a clean pass.
    cfg_t = 8; cfg_d1 = 4; cfg_d2 = 2; krn_blk_valid = 2'b11; out_almostfull = 1'b0;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_run_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
    run_pass(2, 2, 1, 0, 0, 200);
    check_pass(2, 2, 1);

    // Randomized passes with random backpressure.
    for (int p = 0; p < 6; p++) begin
      rt  = $urandom_range(1, 5);
      rd1 = $urandom_range(1, 4);
      rd2 = $urandom_range(1, 3);
      run_pass(rt, rd1, rd2, 1, 0, 2000);
      check_pass(rt, rd1, rd2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
